seven_seg_scan_ctrl: RTL and testbench
======================================

SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 27000, clock cycles per digit slot (1 kHz digit rate at 27 MHz).
REQ-002 SHALL have parameter BLANK_CYCLES, default 16, anti-ghosting gap per slot; legal range 1 <= BLANK_CYCLES < SCAN_DIV.
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 load_valid  input  1  new display value offered.
REQ-006 load_ready  output  1  controller can accept a value.
REQ-007 load_value  input  16  four BCD digits; [3:0] = digit 0 (rightmost).
REQ-008 dp_in  input  4  decimal point per digit, sampled with load_value.
REQ-009 seg  output  7  segments {a,b,c,d,e,f,g}, active high.
REQ-010 dp  output  1  decimal point of the enabled digit, active high.
REQ-011 digit_en  output  4  one-hot active-high digit enable.

Function
REQ-012 FSM states BLANK and SHOW; each digit slot = BLANK for BLANK_CYCLES cycles, then SHOW for SCAN_DIV-BLANK_CYCLES cycles.
REQ-013 Digit index SHALL advance 0->1->2->3->0 at SHOW->BLANK; the 3->0 step is the frame boundary.
REQ-014 In BLANK, digit_en SHALL be 0000; in SHOW, digit_en SHALL be 1<<index.
REQ-015 seg and dp SHALL be registered and loaded with the current digit's pattern on the BLANK-entry edge, stable throughout that slot.
REQ-016 Encoding: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011; nibbles 10-15 SHALL give 0000000.
REQ-017 Handshake: transfer when load_valid && load_ready; value and dp_in SHALL go to a shadow register and set pending.
REQ-018 load_ready SHALL equal !pending; load_valid while load_ready=0 SHALL be ignored and not lost from the requester's view (no acceptance).
REQ-019 At a frame boundary with pending set (as registered before that edge), the shadow SHALL copy into the display register and pending SHALL clear; load_ready returns high the next cycle.
REQ-020 A transfer in the boundary cycle itself SHALL apply at the following frame boundary.
REQ-021 Display register changes only at frame boundaries; no frame shows mixed old/new digits.

Reset
REQ-022 While rst_n=0 at a clock edge: digit_en=0000, seg=0000000, dp=0, load_ready=1, pending=0, display and shadow registers=0, index=0, state=BLANK, slot counter=0.
REQ-023 Reset asserted mid-slot SHALL take effect on the next edge, discarding any pending value.
REQ-024 After release, first SHOW (digit 0, pattern 1111110) SHALL begin BLANK_CYCLES cycles later.

Configuration
REQ-025 Macro SEVEN_SEG_LZS_EN: when defined, digits 3..1 whose value and all higher digits are zero SHALL be suppressed (digit_en stays 0000, seg=0000000 for that slot); digit 0 always shown.
REQ-026 Without SEVEN_SEG_LZS_EN, all four digits SHALL be shown; slot timing identical in both builds.

Structure
REQ-027 Package seven_seg_pkg SHALL hold segment pattern constants, NUM_DIGITS=4, and the BLANK/SHOW state typedef.
REQ-028 BCD-to-segment lookup SHALL be sub-module seven_seg_decoder, instantiated once and time-shared across digits.

Verification (SCAN_DIV=8, BLANK_CYCLES=2)
REQ-029 Reset: rst_n low 3 cycles -> digit_en=0000, seg=0000000, load_ready=1; after release digit_en=0001 with seg=1111110 from cycle 2 to 7.
REQ-030 Load 0x1234 -> after next boundary digits 0..3 show 0110011, 1111001, 1101101, 0110000; each enable high 6 cycles, low 2.
REQ-031 Second load_valid while pending -> load_ready=0, second value not accepted until the cycle after boundary; display never shows a torn frame.
REQ-032 Load 0x00A5 -> digit 1 slot seg=0000000, digit 0 seg=1011011.
REQ-033 With SEVEN_SEG_LZS_EN, load 0x0007 -> only digit_en=0001 ever asserts; load 0x0000 -> digit 0 shows 1111110; without macro, digit 3 shows 1111110.
REQ-034 Reset during SHOW of digit 2 with pending set -> next edge all outputs at reset values, load_ready=1, old value not displayed.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the multiplexed seven-segment scan controller.
// Optional leading-zero suppression is selected with the SEVEN_SEG_LZS_EN macro.
package seven_seg_pkg;

    localparam int NUM_DIGITS = 4;

    // Segment order {a,b,c,d,e,f,g}, active high
    localparam logic [6:0] SEG_0   = 7'b1111110;
    localparam logic [6:0] SEG_1   = 7'b0110000;
    localparam logic [6:0] SEG_2   = 7'b1101101;
    localparam logic [6:0] SEG_3   = 7'b1111001;
    localparam logic [6:0] SEG_4   = 7'b0110011;
    localparam logic [6:0] SEG_5   = 7'b1011011;
    localparam logic [6:0] SEG_6   = 7'b1011111;
    localparam logic [6:0] SEG_7   = 7'b1110000;
    localparam logic [6:0] SEG_8   = 7'b1111111;
    localparam logic [6:0] SEG_9   = 7'b1111011;
    localparam logic [6:0] SEG_OFF = 7'b0000000;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

endpackage

// File: rtl/seven_seg_decoder.sv
// BCD nibble to seven-segment pattern; non-decimal nibbles render as all-off.
module seven_seg_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Pure lookup table
    always_comb begin
        seg = SEG_OFF;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with a valid/ready load port.
// Each digit slot is a blanking gap followed by the lit phase; new values are
// held in a shadow register and only committed at the frame boundary.
// Define SEVEN_SEG_LZS_EN to suppress leading zeros on digits 3..1.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int SCAN_DIV     = 27000,
    parameter int BLANK_CYCLES = 16
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] load_value,
    input  logic [3:0]  dp_in,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  digit_en
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - BLANK_CYCLES - 1);

    state_t                state, state_next;
    logic [CW-1:0]         cnt, cnt_next;
    logic [1:0]            idx, idx_next;
    logic                  boundary;
    logic                  pending, pending_next;
    logic [15:0]           disp, disp_next, shadow;
    logic [NUM_DIGITS-1:0] disp_dp, disp_dp_next, shadow_dp;
    logic                  xfer, commit;
    logic [3:0]            nibble;
    logic [6:0]            dec_seg;
    logic                  suppress, supp_q;

    assign load_ready = !pending;
    assign xfer       = load_valid && load_ready;
    assign commit     = boundary && pending;

    // Slot sequencing, frame-boundary commit and the next digit to be decoded
    always_comb begin
        state_next   = state;
        cnt_next     = cnt + CW'(1);
        idx_next     = idx;
        boundary     = 1'b0;
        case (state)
            BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_next = SHOW;
                    cnt_next   = '0;
                end
            end
            SHOW: begin
                if (cnt == SHOW_LAST) begin
                    state_next = BLANK;
                    cnt_next   = '0;
                    idx_next   = idx + 2'd1;
                    boundary   = (idx == 2'd3);
                end
            end
            default: begin
                state_next = BLANK;
                cnt_next   = '0;
            end
        endcase

        disp_next    = commit ? shadow    : disp;
        disp_dp_next = commit ? shadow_dp : disp_dp;

        pending_next = pending;
        if (commit)
            pending_next = 1'b0;
        else if (xfer)
            pending_next = 1'b1;

        nibble = disp_next[4*idx_next +: 4];

`ifdef SEVEN_SEG_LZS_EN
        case (idx_next)
            2'd3:    suppress = (disp_next[15:12] == 4'd0);
            2'd2:    suppress = (disp_next[15:8]  == 8'd0);
            2'd1:    suppress = (disp_next[15:4]  == 12'd0);
            default: suppress = 1'b0;
        endcase
`else
        suppress = 1'b0;
`endif
    end

    seven_seg_decoder u_dec (
        .bcd (nibble),
        .seg (dec_seg)
    );

    // FSM state, slot counter and digit index
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= BLANK;
            cnt   <= '0;
            idx   <= 2'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            idx   <= idx_next;
        end
    end

    // Load handshake: shadow capture and display commit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending   <= 1'b0;
            shadow    <= '0;
            shadow_dp <= '0;
            disp      <= '0;
            disp_dp   <= '0;
        end else begin
            pending <= pending_next;
            disp    <= disp_next;
            disp_dp <= disp_dp_next;
            if (xfer) begin
                shadow    <= load_value;
                shadow_dp <= dp_in;
            end
        end
    end

    // Segment outputs are (re)loaded on every edge into BLANK so the pattern is
    // settled before the digit is enabled; the first slot after reset has no
    // SHOW->BLANK edge, so loading on BLANK->BLANK edges covers it too.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg    <= SEG_OFF;
            dp     <= 1'b0;
            supp_q <= 1'b0;
        end else if (state_next == BLANK) begin
            seg    <= suppress ? SEG_OFF : dec_seg;
            dp     <= suppress ? 1'b0 : disp_dp_next[idx_next];
            supp_q <= suppress;
        end
    end

    // One-hot digit drive during the lit phase only
    always_comb begin
        digit_en = '0;
        if (state == SHOW && !supp_q)
            digit_en = 4'b0001 << idx;
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with SCAN_DIV=8, BLANK_CYCLES=2
// (32-cycle frames). Build with SEVEN_SEG_LZS_EN to check the suppression build.
module tb_seven_seg_scan_ctrl;

    localparam logic [6:0] P0 = 7'b1111110, P1 = 7'b0110000, P2 = 7'b1101101,
                           P3 = 7'b1111001, P4 = 7'b0110011, P5 = 7'b1011011,
                           P6 = 7'b1011111, P7 = 7'b1110000, P8 = 7'b1111111,
                           P9 = 7'b1111011, POFF = 7'b0000000;

`ifdef SEVEN_SEG_LZS_EN
    localparam logic [3:0] MK_A5 = 4'b0011, MK_07 = 4'b0001, MK_00 = 4'b0001, MK_0100 = 4'b0111;
`else
    localparam logic [3:0] MK_A5 = 4'b1111, MK_07 = 4'b1111, MK_00 = 4'b1111, MK_0100 = 4'b1111;
`endif

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dpv;
        logic [27:0] segs;   // {digit3, digit2, digit1, digit0}
        logic [3:0]  mask;   // digits expected to light
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, load_valid, load_ready, dp;
    logic [15:0] load_value;
    logic [3:0]  dp_in, digit_en;
    logic [6:0]  seg;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    vec_t vecs[7];
    vec_t vzero, vx, vy, vz;

    seven_seg_scan_ctrl #(.SCAN_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_value (load_value),
        .dp_in      (dp_in),
        .seg        (seg),
        .dp         (dp),
        .digit_en   (digit_en)
    );

    always #5 clk = ~clk;

    // Cycle index since the last reset edge
    always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic wait_cyc(input int f);
        int guard = 0;
        while (cyc < f && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != f) begin
            n_tests++;
            n_fail++;
            $display("FAIL reach cycle: got %0d expected %0d", cyc, f);
        end
    endtask

    function automatic int frame_of(input int t);
        return (t % 32 == 31) ? (t / 32 + 2) * 32 : (t / 32 + 1) * 32;
    endfunction

    task automatic check_frame(input int f, input vec_t v, input string tag);
        wait_cyc(f);
        for (int k = 0; k < 32; k++) begin
            int d, ph;
            logic shown;
            d = k / 8;
            ph = k % 8;
            shown = (ph >= 2) && v.mask[d];
            chk($sformatf("%s digit_en k%0d", tag, k), 32'(digit_en),
                32'(shown ? (4'b0001 << d) : 4'b0000));
            if (ph >= 2)
                chk($sformatf("%s seg d%0d k%0d", tag, d, k), 32'(seg),
                    32'(v.mask[d] ? v.segs[7*d +: 7] : POFF));
            if (shown)
                chk($sformatf("%s dp d%0d k%0d", tag, d, k), 32'(dp), 32'(v.dpv[d]));
            @(negedge clk);
        end
    endtask

    task automatic do_load(input logic [15:0] val, input logic [3:0] dpv, output int t);
        int guard = 0;
        logic done = 1'b0;
        t = -1;
        load_value = val;
        dp_in = dpv;
        load_valid = 1'b1;
        while (!done && guard < 200) begin
            if (load_ready) begin
                t = cyc;
                done = 1'b1;
            end
            @(negedge clk);
            guard++;
        end
        load_valid = 1'b0;
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL load accept: got timeout expected acceptance of %0h", val);
        end
    endtask

    initial begin
        int t, t1, t2, t3, t4, f1, base;

        vzero   = '{16'h0000, 4'b0000, {P0, P0, P0, P0}, MK_00};
        vecs[0] = '{16'h1234, 4'b0000, {P1, P2, P3, P4}, 4'b1111};
        vecs[1] = '{16'h00A5, 4'b0001, {P0, P0, POFF, P5}, MK_A5};
        vecs[2] = '{16'h9876, 4'b0101, {P9, P8, P7, P6}, 4'b1111};
        vecs[3] = '{16'h0007, 4'b1110, {P0, P0, P0, P7}, MK_07};
        vecs[4] = '{16'hFBCD, 4'b1111, {POFF, POFF, POFF, POFF}, 4'b1111};
        vecs[5] = '{16'h0000, 4'b0010, {P0, P0, P0, P0}, MK_00};
        vecs[6] = '{16'h0100, 4'b0100, {P0, P1, P0, P0}, MK_0100};
        vx      = '{16'h1111, 4'b1000, {P1, P1, P1, P1}, 4'b1111};
        vy      = '{16'h2222, 4'b0110, {P2, P2, P2, P2}, 4'b1111};
        vz      = '{16'h3456, 4'b0000, {P3, P4, P5, P6}, 4'b1111};

        rst_n = 1'b0;
        load_valid = 1'b0;
        load_value = '0;
        dp_in = '0;

        // Reset held for three edges
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset digit_en", 32'(digit_en), 32'h0);
        chk("reset seg", 32'(seg), 32'h0);
        chk("reset dp", 32'(dp), 32'h0);
        chk("reset load_ready", 32'(load_ready), 32'h1);
        rst_n = 1'b1;
        check_frame(0, vzero, "post-reset");

        // Table of display values
        for (int i = 0; i < 7; i++) begin
            do_load(vecs[i].value, vecs[i].dpv, t);
            check_frame(frame_of(t), vecs[i], $sformatf("vec%0d", i));
        end

        // Second offer while pending: held off until the cycle after the boundary
        do_load(vx.value, vx.dpv, t1);
        f1 = frame_of(t1);
        chk("ready low while pending", 32'(load_ready), 32'h0);
        fork
            do_load(vy.value, vy.dpv, t2);
            check_frame(f1, vx, "first-of-two");
        join
        chk("second accept cycle", 32'(t2), 32'(f1));
        check_frame(frame_of(t2), vy, "second-of-two");

        // Transfer in the boundary cycle itself waits a whole frame
        base = cyc;
        wait_cyc(base + 31);
        do_load(vz.value, vz.dpv, t3);
        chk("boundary-cycle accept", 32'(t3), 32'(base + 31));
        check_frame(base + 32, vy, "old-kept");
        check_frame(base + 64, vz, "boundary-load");

        // Reset during digit 2 SHOW with a value pending
        base = cyc;
        do_load(16'h7890, 4'b1111, t4);
        wait_cyc(base + 20);
        chk("pre-reset digit_en", 32'(digit_en), 32'h4);
        chk("pre-reset pending", 32'(load_ready), 32'h0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrun reset digit_en", 32'(digit_en), 32'h0);
        chk("midrun reset seg", 32'(seg), 32'h0);
        chk("midrun reset dp", 32'(dp), 32'h0);
        chk("midrun reset load_ready", 32'(load_ready), 32'h1);
        rst_n = 1'b1;
        check_frame(0, vzero, "after-reset-f0");
        check_frame(32, vzero, "after-reset-f1");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
